multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the multi-cycle RV32I-subset core.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the 2-bit ALUOp consumed by the ALU control decoder, plus all register-file, PC, IR and memory strobes.
- Handles a ready-based memory handshake with a timeout, and latches a sticky fault on illegal opcodes or memory timeouts.

Parameters:
- TIMEOUT, 15: maximum wait cycles for mem_ready in FETCH/MEM before FAULT; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  inst[6:0] from the IR output; valid from DECODE onward.
- br_taken  in  1  ALU compare result (beq: equal; blt: signed less-than); sampled in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_op  out  2  00 add (addi/lw/sw), 01 branch compare, 10 R-type, 11 jal.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- ir_we  out  1  load the IR from memory read data.
- pc_we  out  1  update the PC.
- pc_sel  out  1  0 = PC+4, 1 = branch/jal target.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a store (only with mem_req).
- reg_we  out  1  register-file write.
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky error flag.
- state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- While rst=1: all outputs are 0. On the next edge, state=FETCH and the wait counter is 0.
- Reset mid-operation aborts the instruction. No strobe is asserted in the reset cycle; FETCH restarts cleanly.
- Outputs are combinational from state plus the latched instruction class. ir_we, pc_we, reg_we and retire in the wait states also depend on mem_ready.
- FETCH:
  - mem_req=1, mem_we=0.
  - If mem_ready: ir_we=1, go to DECODE.
  - Otherwise the counter increments. When the counter equals TIMEOUT (TIMEOUT>0) and mem_ready=0, go to FAULT.
  - mem_ready in the same cycle as timeout expiry wins: the transfer completes.
- DECODE (1 cycle): classify opcode and latch the class.
  - 0110011 R
  - 0010011 I
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BR
  - 1101111 JAL
  - Any other opcode goes to FAULT.
  - Otherwise go to EXEC. The wait counter is cleared.
- EXEC (1 cycle): alu_op = R:10, I/LOAD/STORE:00, BR:01, JAL:11. alu_src_b=1 for I/LOAD/STORE, 0 otherwise.
  - BR: pc_we=1, pc_sel=br_taken, retire=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - R/I/JAL: go to WB.
- MEM:
  - mem_req=1, mem_we=1 for STORE; alu_op=00 and alu_src_b=1 are held.
  - Same wait/timeout rules as FETCH.
  - On mem_ready:
    - LOAD goes to WB.
    - STORE asserts pc_we=1, pc_sel=0, retire=1 and goes to FETCH.
- WB (1 cycle): reg_we=1, pc_we=1, retire=1, go to FETCH.
  - R/I: wb_sel=00, pc_sel=0.
  - LOAD: wb_sel=01, pc_sel=0.
  - JAL: wb_sel=10, pc_sel=1; alu_op=11 is held.
- FAULT: all strobes 0, fault=1. The state persists until rst.
- Invariants:
  - pc_we and retire fire exactly once per instruction.
  - reg_we never fires for STORE or BR.
  - mem_we never fires without mem_req.
- Instruction latency with zero-wait memory (mem_ready=1 in the request cycle):
  - BR: 3 cycles
  - R, I, JAL: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
  - Each wait cycle adds 1.

Test Plan:
- R-type add (opcode 0110011), mem_ready=1 → states 0,1,2,4. EXEC alu_op=10, alu_src_b=0. WB reg_we=1, wb_sel=00, pc_we=1, pc_sel=0. retire after 4 cycles.
- beq with br_taken=1, then with br_taken=0 → EXEC alu_op=01, pc_we=1, pc_sel=1 then 0. reg_we never asserted. 3 cycles each.
- lw with mem_ready low for 3 cycles in MEM → mem_req=1, mem_we=0 held for 4 cycles. Then WB wb_sel=01, reg_we=1. Total 8 cycles.
- sw, then jal → store: mem_we=1 in MEM, pc_we on mem_ready, no reg_we. jal: EXEC alu_op=11, WB wb_sel=10, pc_sel=1, reg_we=1.
- FETCH with mem_ready held 0, TIMEOUT=15 → FAULT after 16 FETCH cycles, fault=1 sticky. Opcode 1111111 in DECODE → FAULT next cycle. rst=1 → FETCH, fault=0.
- rst asserted in MEM of a sw → all outputs 0 that cycle, no pc_we or retire. FETCH with mem_req=1 the following cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with ready handshake, timeout and sticky fault
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       fault,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd7
  } state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL} cls_t;
  state_t cur, nxt;
  cls_t cls, dec_cls;
  logic dec_ok, expired;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  assign expired = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT));
  always_comb begin
    dec_ok = 1'b1;
    dec_cls = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_ok = 1'b0;
    endcase
  end
  // A wait state completes on mem_ready even in the cycle the timeout expires.
  always_comb begin
    nxt = cur;
    cnt_nxt = '0;
    case (cur)
      FETCH: begin
        nxt = mem_ready ? DECODE : expired ? FAULT : FETCH;
        cnt_nxt = mem_ready ? '0 : cnt + 1'b1;
      end
      DECODE: nxt = dec_ok ? EXEC : FAULT;
      EXEC:   nxt = (cls == C_BR) ? FETCH : (cls == C_LOAD || cls == C_STORE) ? MEM : WB;
      MEM: begin
        nxt = mem_ready ? ((cls == C_LOAD) ? WB : FETCH) : expired ? FAULT : MEM;
        cnt_nxt = mem_ready ? '0 : cnt + 1'b1;
      end
      WB:      nxt = FETCH;
      FAULT:   nxt = FAULT;
      default: nxt = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      cnt <= '0;
      cls <= C_R;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      if (cur == DECODE) cls <= dec_cls;
    end
  end
  // Outputs are forced low during reset so an aborted instruction emits no strobe.
  always_comb begin
    alu_op = 2'b00;
    alu_src_b = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    reg_we = 1'b0;
    wb_sel = 2'b00;
    retire = 1'b0;
    fault = 1'b0;
    state = rst ? 3'd0 : cur;
    if (!rst) begin
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          ir_we = mem_ready;
        end
        EXEC: begin
          alu_op = (cls == C_R) ? 2'b10 : (cls == C_BR) ? 2'b01 : (cls == C_JAL) ? 2'b11 : 2'b00;
          alu_src_b = cls inside {C_I, C_LOAD, C_STORE};
          pc_we = (cls == C_BR);
          pc_sel = (cls == C_BR) && br_taken;
          retire = (cls == C_BR);
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we = (cls == C_STORE);
          alu_src_b = 1'b1;
          pc_we = (cls == C_STORE) && mem_ready;
          retire = (cls == C_STORE) && mem_ready;
        end
        WB: begin
          reg_we = 1'b1;
          pc_we = 1'b1;
          retire = 1'b1;
          pc_sel = (cls == C_JAL);
          alu_op = (cls == C_JAL) ? 2'b11 : 2'b00;
          wb_sel = (cls == C_LOAD) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
